// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register file.
// Selects the write-back word from the MEM/WB outputs, commits it into the
// architectural register file, and serves the two decode-stage read ports.
// Register 0 is hardwired to zero. A sticky flag records any write cycle
// that had both data selects asserted, and a free-running counter tracks
// committed writes.
// Optional build macro: RF_BYPASS_EN -- when defined, a read port that
// addresses the register being written in the current cycle returns the
// incoming write-back data before the edge instead of the stored value.
module wb_regfile #(
    parameter int WORD_LEN  = 32,
    parameter int REG_COUNT = 32,
    parameter int ADDR_LEN  = 5,
    parameter int CNT_LEN   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WORD_LEN-1:0] wb_mem_out,
    input  logic [WORD_LEN-1:0] wb_alu_out,
    input  logic [WORD_LEN-1:0] wb_rf_wdata,
    input  logic                wb_sel_mem,
    input  logic                wb_sel_alu,
    input  logic                wb_write_en,
    input  logic [ADDR_LEN-1:0] wb_dst,
    input  logic [ADDR_LEN-1:0] rd_addr_a,
    input  logic [ADDR_LEN-1:0] rd_addr_b,
    output logic [WORD_LEN-1:0] rd_data_a,
    output logic [WORD_LEN-1:0] rd_data_b,
    output logic [WORD_LEN-1:0] wb_data,
    output logic                sel_conflict,
    output logic [CNT_LEN-1:0]  commit_cnt
);

    // A write only commits when requested and not aimed at the zero register.
    logic                commit;
    // Both selects high on a requested write, whatever the destination.
    logic                conflict_hit;
    // Flattened view of the architectural state, entry 0 tied to zero.
    logic [WORD_LEN-1:0] reg_file [REG_COUNT];
    // Stored values seen by each read port before any bypass.
    logic [WORD_LEN-1:0] stored_a;
    logic [WORD_LEN-1:0] stored_b;

    logic [CNT_LEN-1:0]  cnt_reg;
    logic [CNT_LEN-1:0]  cnt_next;
    logic                conflict_reg;
    logic                conflict_next;

    // Write-back source select; memory data wins when both selects are high.
    always_comb begin
        wb_data = wb_rf_wdata;
        if (wb_sel_mem) begin
            wb_data = wb_mem_out;
        end else if (wb_sel_alu) begin
            wb_data = wb_alu_out;
        end
    end

    assign commit       = wb_write_en && (wb_dst != '0);
    assign conflict_hit = wb_write_en && wb_sel_mem && wb_sel_alu;

    // One storage entry per register; entry 0 has no storage at all.
    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign reg_file[gi] = '0;
            end else begin : g_entry
                logic                wr_sel;
                logic [WORD_LEN-1:0] entry_reg;

                assign wr_sel = commit && (wb_dst == ADDR_LEN'(gi));

                // Capture the write-back word when this entry is the target.
                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        entry_reg <= '0;
                    end else if (wr_sel) begin
                        entry_reg <= wb_data;
                    end
                end

                assign reg_file[gi] = entry_reg;
            end
        end
    endgenerate

    assign stored_a = reg_file[rd_addr_a];
    assign stored_b = reg_file[rd_addr_b];

`ifdef RF_BYPASS_EN
    // Forward the in-flight write to a matching read port in the same cycle.
    // commit already excludes index 0, so register 0 still reads zero.
    always_comb begin
        rd_data_a = stored_a;
        rd_data_b = stored_b;
        if (commit && (rd_addr_a == wb_dst)) begin
            rd_data_a = wb_data;
        end
        if (commit && (rd_addr_b == wb_dst)) begin
            rd_data_b = wb_data;
        end
    end
`else
    // Without bypass the ports show stored state until the commit edge.
    always_comb begin
        rd_data_a = stored_a;
        rd_data_b = stored_b;
    end
`endif

    // Next-state for the commit counter (wraps) and the sticky conflict flag.
    always_comb begin
        cnt_next      = cnt_reg;
        conflict_next = conflict_reg;
        if (commit) begin
            cnt_next = cnt_reg + CNT_LEN'(1);
        end
        if (conflict_hit) begin
            conflict_next = 1'b1;
        end
    end

    // Debug state register; only reset clears the conflict flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            conflict_reg <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            conflict_reg <= conflict_next;
        end
    end

    assign commit_cnt   = cnt_reg;
    assign sel_conflict = conflict_reg;

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Write-back end of the MEM/WB pipeline register: consumes the registered MEM/WB outputs, selects the write-back data, and commits it into the architectural register file.
- Provides the two decode-stage read ports.
- Keeps a sticky select-conflict flag and a commit counter for debug and verification.

Parameters:
- WORD_LEN, 32, width of data words and register entries.
- REG_COUNT, 32, number of architectural registers (power of two).
- ADDR_LEN, 5, register address width; equals log2(REG_COUNT).
- CNT_LEN, 32, width of the commit counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- wb_mem_out  input  WORD_LEN  data-memory read data from MEM/WB.
- wb_alu_out  input  WORD_LEN  ALU result from MEM/WB.
- wb_rf_wdata  input  WORD_LEN  pass-through write data from MEM/WB (link/immediate).
- wb_sel_mem  input  1  select memory data for write-back.
- wb_sel_alu  input  1  select ALU data for write-back.
- wb_write_en  input  1  register-file write request.
- wb_dst  input  ADDR_LEN  destination register index.
- rd_addr_a  input  ADDR_LEN  read port A index.
- rd_addr_b  input  ADDR_LEN  read port B index.
- rd_data_a  output  WORD_LEN  read port A data, combinational.
- rd_data_b  output  WORD_LEN  read port B data, combinational.
- wb_data  output  WORD_LEN  selected write-back data, combinational; also feeds the forwarding unit.
- sel_conflict  output  1  sticky flag: wb_sel_mem and wb_sel_alu were both high on a write.
- commit_cnt  output  CNT_LEN  count of committed register writes.

Behaviour:
- Data select (combinational):
  - wb_sel_mem=1: wb_data = wb_mem_out. This takes priority when both selects are high.
  - wb_sel_mem=0, wb_sel_alu=1: wb_data = wb_alu_out.
  - Both selects 0: wb_data = wb_rf_wdata.
- Commit condition: rising clk edge with wb_write_en=1 and wb_dst != 0.
  - On commit, regs[wb_dst] <= wb_data and commit_cnt <= commit_cnt + 1.
  - commit_cnt wraps to 0 after all-ones; there is no saturation.
- Register 0 is hardwired to zero.
  - Writes to index 0 are dropped and do not increment commit_cnt.
  - Reads of index 0 return 0 on both ports.
- wb_write_en=0: no array change, no counter change, regardless of the selects.
- Reads are asynchronous: rd_data_x = regs[rd_addr_x] (0 for index 0). Both ports may address the same register; both return the same value.
- Write-to-read same cycle: behaviour depends on RF_BYPASS_EN (see Optional Feature).
- sel_conflict:
  - Set on a rising edge where wb_write_en=1, wb_sel_mem=1 and wb_sel_alu=1.
  - Set even when wb_dst=0.
  - Cleared only by rst. The write itself still proceeds using memory data.
- Reset (async, immediate on rst assertion):
  - All registers are 0, commit_cnt=0, sel_conflict=0.
  - With all registers 0, rd_data_a and rd_data_b are 0.
  - Assertion mid-write discards that write.
  - The first commit is possible on the first rising edge after rst deasserts.
- Latency:
  - Write visible on the read ports the cycle after the commit edge (or the same cycle with bypass).
  - Counter and flag update at the commit edge.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: internal bypass. If wb_write_en=1, wb_dst != 0 and rd_addr_x == wb_dst, then rd_data_x = wb_data in the same cycle, before the edge. This resolves the WB-to-ID hazard without a stall.
- Undefined: no bypass. rd_data_x returns the stored value until the edge. The hazard unit must stall one cycle, or the forwarding unit must use wb_data.
- Index 0 always reads 0 in both configurations.

Test Plan:
- Reset check: assert rst mid-cycle after several writes → every register reads 0, commit_cnt=0, sel_conflict=0 immediately, without waiting for a clock edge.
- Source select: three write cycles.
  - wb_sel_mem=1, wb_mem_out=0xDEADBEEF, dst=3 → r3=0xDEADBEEF.
  - wb_sel_alu=1, wb_alu_out=0x12345678, dst=4 → r4=0x12345678.
  - Both selects 0, wb_rf_wdata=0x00000040, dst=31 → r31=0x40.
  - commit_cnt=3 after the three writes.
- R0 protection: write 0xFFFFFFFF to dst=0 with wb_write_en=1 → rd_data_a(addr 0)=0, commit_cnt unchanged.
- Select conflict: wb_sel_mem=wb_sel_alu=1, mem=0xAAAA0000, alu=0x5555, dst=7 → r7=0xAAAA0000 and sel_conflict=1. sel_conflict remains 1 across 10 later clean writes and clears only on rst.
- Same-cycle read/write: r5=0x1, write 0x2 to dst=5 while rd_addr_a=rd_addr_b=5.
  - With RF_BYPASS_EN: both ports read 0x2 before the edge.
  - Without RF_BYPASS_EN: both ports read 0x1 before the edge and 0x2 after it.
- Counter wrap: build with CNT_LEN=4 and issue 17 valid writes → commit_cnt=1. wb_write_en=0 cycles interleaved between them do not change the count.
